time_set_ctrl: RTL and testbench

//  Time-keeping and setting sequencer that drives the 7-segment display controller.

---
 rtl/time_set_ctrl_if.sv | 37 +++
 rtl/time_set_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Bus bundle for time_set_ctrl: button/strobe inputs and time/status outputs.
// The master side drives the buttons and the strobe; the slave side is the controller.
interface time_set_ctrl_if;
    logic       sec_p;
    logic       btn_mode;
    logic       btn_up;
    logic [3:0] master_status;
    logic [4:0] nowH;
    logic [5:0] nowM;
    logic [4:0] timerH;
    logic [5:0] timerM;
    logic       alarm;

    modport master (
        output sec_p,
        output btn_mode,
        output btn_up,
        input  master_status,
        input  nowH,
        input  nowM,
        input  timerH,
        input  timerM,
        input  alarm
    );

    modport slave (
        input  sec_p,
        input  btn_mode,
        input  btn_up,
        output master_status,
        output nowH,
        output nowM,
        output timerH,
        output timerM,
        output alarm
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time keeping / setting sequencer: button debounce, 8 digit-edit states plus run.
// Optional alarm logic is built when TIME_SET_ALARM_EN is defined.
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 20000,
    parameter int unsigned SEC_PER_MIN  = 60,
    parameter int unsigned ALARM_SEC    = 30
) (
    input logic            mclk,
    input logic            rst_n,
    time_set_ctrl_if.slave bus
);

    localparam int unsigned DCW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned SCW = $clog2(SEC_PER_MIN + 1);

    if (DEBOUNCE_CYC < 1) begin : g_bad_dbnc
        $error("DEBOUNCE_CYC must be at least 1");
    end
    if (SEC_PER_MIN < 1) begin : g_bad_spm
        $error("SEC_PER_MIN must be at least 1");
    end
    if (ALARM_SEC < 1) begin : g_bad_alarm
        $error("ALARM_SEC must be at least 1");
    end

    typedef enum logic [3:0] {
        S_D0  = 4'd0,
        S_D1  = 4'd1,
        S_D2  = 4'd2,
        S_D3  = 4'd3,
        S_D4  = 4'd4,
        S_D5  = 4'd5,
        S_D6  = 4'd6,
        S_D7  = 4'd7,
        S_RUN = 4'd8
    } state_e;

    // Hour tens digit step 0->1->2->0; ones clamped to 3 when tens becomes 2.
    function automatic logic [4:0] hr_tens_up(input logic [4:0] h);
        logic [4:0] r;
        if (h >= 5'd20) begin
            r = h - 5'd20;
        end else if (h >= 5'd10) begin
            r = (h > 5'd13) ? 5'd23 : h + 5'd10;
        end else begin
            r = h + 5'd10;
        end
        return r;
    endfunction

    // Hour ones digit step; wraps after 9, or after 3 in the twenties.
    function automatic logic [4:0] hr_ones_up(input logic [4:0] h);
        logic [4:0] r;
        if (h == 5'd23) begin
            r = 5'd20;
        end else if (h == 5'd9 || h == 5'd19) begin
            r = h - 5'd9;
        end else begin
            r = h + 5'd1;
        end
        return r;
    endfunction

    // Minute tens digit step; wraps after 5.
    function automatic logic [5:0] mn_tens_up(input logic [5:0] m);
        return (m >= 6'd50) ? m - 6'd50 : m + 6'd10;
    endfunction

    // Minute ones digit step; wraps after 9.
    function automatic logic [5:0] mn_ones_up(input logic [5:0] m);
        return ((m % 6'd10) == 6'd9) ? m - 6'd9 : m + 6'd1;
    endfunction

    // Index 0 = mode button, index 1 = up button.
    logic [1:0]          btn_raw;
    logic [1:0]          s1_q;
    logic [1:0]          s2_q;
    logic [1:0]          db_q;
    logic [1:0]          db_d;
    logic [1:0]          pls_q;
    logic [1:0]          pls_d;
    logic [1:0][DCW-1:0] dc_q;
    logic [1:0][DCW-1:0] dc_d;

    state_e   state_q;
    state_e   state_d;
    logic [4:0] now_h_q;
    logic [4:0] now_h_d;
    logic [5:0] now_m_q;
    logic [5:0] now_m_d;
    logic [4:0] tmr_h_q;
    logic [4:0] tmr_h_d;
    logic [5:0] tmr_m_q;
    logic [5:0] tmr_m_d;
    logic [SCW-1:0] sec_cnt_q;
    logic [SCW-1:0] sec_cnt_d;

    logic run;
    logic roll;
    logic eat;
    logic mode_go;
    logic up_go;

    assign btn_raw = {bus.btn_up, bus.btn_mode};

    // Two-flop synchroniser for the raw buttons.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Accept a new level after it differs for DEBOUNCE_CYC cycles; pulse on rise.
    always_comb begin
        db_d = db_q;
        dc_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (dc_q[i] == DCW'(DEBOUNCE_CYC - 1)) begin
                    db_d[i] = s2_q[i];
                end else begin
                    dc_d[i] = dc_q[i] + 1'b1;
                end
            end
        end
        pls_d = db_d & ~db_q;
    end

    // Debounce state and press pulse registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= '0;
            dc_q  <= '0;
            pls_q <= '0;
        end else begin
            db_q  <= db_d;
            dc_q  <= dc_d;
            pls_q <= pls_d;
        end
    end

    assign run     = (state_q == S_RUN);
    assign roll    = run && bus.sec_p &&
                     (sec_cnt_q == SCW'(SEC_PER_MIN - 1));
    assign mode_go = pls_q[0] & ~eat;
    assign up_go   = pls_q[1] & ~pls_q[0] & ~eat;

    // Next state, digit edits and run-time minute counting.
    always_comb begin
        state_d   = state_q;
        now_h_d   = now_h_q;
        now_m_d   = now_m_q;
        tmr_h_d   = tmr_h_q;
        tmr_m_d   = tmr_m_q;
        sec_cnt_d = sec_cnt_q;

        if (mode_go) begin
            state_d = run ? S_D0 : state_e'(state_q + 4'd1);
        end else if (up_go) begin
            unique case (state_q)
                S_D0:    now_h_d = hr_tens_up(now_h_q);
                S_D1:    now_h_d = hr_ones_up(now_h_q);
                S_D2:    now_m_d = mn_tens_up(now_m_q);
                S_D3:    now_m_d = mn_ones_up(now_m_q);
                S_D4:    tmr_h_d = hr_tens_up(tmr_h_q);
                S_D5:    tmr_h_d = hr_ones_up(tmr_h_q);
                S_D6:    tmr_m_d = mn_tens_up(tmr_m_q);
                S_D7:    tmr_m_d = mn_ones_up(tmr_m_q);
                default: ;
            endcase
        end

        if (!run) begin
            sec_cnt_d = '0;
        end else if (bus.sec_p) begin
            if (roll) begin
                sec_cnt_d = '0;
                if (now_m_q == 6'd59) begin
                    now_m_d = '0;
                    now_h_d = (now_h_q == 5'd23) ? 5'd0 : now_h_q + 5'd1;
                end else begin
                    now_m_d = now_m_q + 6'd1;
                end
            end else begin
                sec_cnt_d = sec_cnt_q + 1'b1;
            end
        end
    end

    // Status and time registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_D0;
            now_h_q   <= '0;
            now_m_q   <= '0;
            tmr_h_q   <= '0;
            tmr_m_q   <= '0;
            sec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            now_h_q   <= now_h_d;
            now_m_q   <= now_m_d;
            tmr_h_q   <= tmr_h_d;
            tmr_m_q   <= tmr_m_d;
            sec_cnt_q <= sec_cnt_d;
        end
    end

`ifdef TIME_SET_ALARM_EN
    localparam int unsigned ACW = $clog2(ALARM_SEC + 1);

    logic           alarm_q;
    logic           alarm_d;
    logic [ACW-1:0] acnt_q;
    logic [ACW-1:0] acnt_d;
    logic           match;

    // A press while ringing only silences the alarm.
    assign eat   = alarm_q & (pls_q[0] | pls_q[1]);
    assign match = roll && (now_h_d == tmr_h_q) && (now_m_d == tmr_m_q);

    // Alarm set on a matching rollover, cleared by timeout, press or leaving run.
    always_comb begin
        alarm_d = alarm_q;
        acnt_d  = acnt_q;
        if (!run || eat) begin
            alarm_d = 1'b0;
            acnt_d  = '0;
        end else if (match) begin
            alarm_d = 1'b1;
            acnt_d  = '0;
        end else if (alarm_q && bus.sec_p) begin
            if (acnt_q == ACW'(ALARM_SEC - 1)) begin
                alarm_d = 1'b0;
                acnt_d  = '0;
            end else begin
                acnt_d = acnt_q + 1'b1;
            end
        end
    end

    // Alarm registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
            acnt_q  <= '0;
        end else begin
            alarm_q <= alarm_d;
            acnt_q  <= acnt_d;
        end
    end

    assign bus.alarm = alarm_q;
`else
    assign eat       = 1'b0;
    assign bus.alarm = 1'b0;
`endif

    assign bus.master_status = state_q;
    assign bus.nowH          = now_h_q;
    assign bus.nowM          = now_m_q;
    assign bus.timerH        = tmr_h_q;
    assign bus.timerM        = tmr_m_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl (DEBOUNCE_CYC=4, SEC_PER_MIN=2, ALARM_SEC=3).
// A reference model pushes expected outputs; they are popped and compared once the DUT settles.
module tb_time_set_ctrl;

    localparam int SPM  = 2;
    localparam int ASEC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .DEBOUNCE_CYC(4),
        .SEC_PER_MIN (SPM),
        .ALARM_SEC   (ASEC)
    ) dut (
        .mclk (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int    st;
        int    h;
        int    m;
        int    th;
        int    tm;
        int    al;
        string tag;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    int m_st, m_h, m_m, m_th, m_tm, m_al, m_sc, m_ac;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.st = m_st; e.h = m_h; e.m = m_m;
        e.th = m_th; e.tm = m_tm; e.al = m_al;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".st"}, 32'(bus.master_status), e.st);
            chk({e.tag, ".h"},  32'(bus.nowH),   e.h);
            chk({e.tag, ".m"},  32'(bus.nowM),   e.m);
            chk({e.tag, ".th"}, 32'(bus.timerH), e.th);
            chk({e.tag, ".tm"}, 32'(bus.timerM), e.tm);
            chk({e.tag, ".al"}, 32'(bus.alarm),  e.al);
        end
    endtask

    task automatic model_clear();
        m_st = 0; m_h = 0; m_m = 0; m_th = 0; m_tm = 0;
        m_al = 0; m_sc = 0; m_ac = 0;
    endtask

    // Digit-wise increment of the selected field.
    task automatic model_up();
        int t, o;
        case (m_st)
            0, 1, 4, 5: begin
                t = (m_st < 4) ? m_h / 10 : m_th / 10;
                o = (m_st < 4) ? m_h % 10 : m_th % 10;
                if (m_st == 0 || m_st == 4) begin
                    t = (t + 1) % 3;
                    if (t == 2 && o > 3) o = 3;
                end else begin
                    o = (t == 2) ? (o + 1) % 4 : (o + 1) % 10;
                end
                if (m_st < 4) m_h = t * 10 + o;
                else m_th = t * 10 + o;
            end
            2, 3, 6, 7: begin
                t = (m_st < 4) ? m_m / 10 : m_tm / 10;
                o = (m_st < 4) ? m_m % 10 : m_tm % 10;
                if (m_st == 2 || m_st == 6) t = (t + 1) % 6;
                else o = (o + 1) % 10;
                if (m_st < 4) m_m = t * 10 + o;
                else m_tm = t * 10 + o;
            end
            default: ;
        endcase
    endtask

    task automatic press(input bit mode, input bit up, input int hold);
        @(negedge clk);
        bus.btn_mode = mode;
        bus.btn_up   = up;
        repeat (hold) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_mode(input string tag);
        press(1'b1, 1'b0, 10);
        if (m_al != 0) begin
            m_al = 0; m_ac = 0;
        end else begin
            m_st = (m_st == 8) ? 0 : m_st + 1;
            if (m_st != 8) m_sc = 0;
        end
        push(tag);
        drain();
    endtask

    task automatic do_up(input string tag, input int hold);
        press(1'b0, 1'b1, hold);
        if (m_al != 0) begin
            m_al = 0; m_ac = 0;
        end else begin
            model_up();
        end
        push(tag);
        drain();
    endtask

    task automatic do_both(input string tag);
        press(1'b1, 1'b1, 10);
        if (m_al != 0) begin
            m_al = 0; m_ac = 0;
        end else begin
            m_st = (m_st == 8) ? 0 : m_st + 1;
        end
        push(tag);
        drain();
    endtask

    task automatic do_sec(input string tag);
        bit rolled;
        @(negedge clk);
        bus.sec_p = 1'b1;
        @(negedge clk);
        bus.sec_p = 1'b0;
        @(negedge clk);
        rolled = 1'b0;
        if (m_st == 8) begin
            m_sc++;
            if (m_sc == SPM) begin
                m_sc = 0;
                rolled = 1'b1;
                m_m++;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h = (m_h + 1) % 24;
                end
            end
`ifdef TIME_SET_ALARM_EN
            if (rolled && m_h == m_th && m_m == m_tm) begin
                m_al = 1; m_ac = 0;
            end else if (m_al != 0) begin
                m_ac++;
                if (m_ac == ASEC) begin
                    m_al = 0; m_ac = 0;
                end
            end
`endif
        end
        push(tag);
        drain();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        push(tag);
        drain();
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic alarm_setup();
        for (int i = 0; i < 7; i++) do_mode("a_mode");
        do_up("a_tm", 10);
        do_mode("a_run");
        do_sec("a_s1");
        do_sec("a_s2");
    endtask

    initial begin
        bus.sec_p    = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        push("rst0");
        drain();
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 1; k <= 8; k++) do_mode($sformatf("mode%0d", k));
        chk("st_run", 32'(bus.master_status), 8);
        do_mode("mode_wrap");
        chk("st_wrap", 32'(bus.master_status), 0);

        do_up("h10", 10);
        do_up("h20", 10);
        chk("h_20", 32'(bus.nowH), 20);
        do_mode("to1");
        for (int i = 0; i < 3; i++) do_up("h2x", 10);
        chk("h_23", 32'(bus.nowH), 23);
        do_up("h_wrap", 10);
        chk("h_ones_wrap", 32'(bus.nowH), 20);

        do_reset("rst1");
        do_up("c_h10", 10);
        do_mode("c_to1");
        for (int i = 0; i < 9; i++) do_up("c_h1x", 10);
        chk("h_19", 32'(bus.nowH), 19);
        for (int i = 0; i < 8; i++) do_mode("c_cyc");
        do_up("c_clamp", 10);
        chk("clamp", 32'(bus.nowH), 23);

        do_mode("d_to1");
        do_mode("d_to2");
        for (int i = 0; i < 5; i++) do_up("d_mt", 10);
        do_mode("d_to3");
        for (int i = 0; i < 9; i++) do_up("d_mo", 10);
        chk("m_59", 32'(bus.nowM), 59);
        do_sec("d_edit_sec");
        for (int i = 0; i < 5; i++) do_mode("d_torun");
        do_sec("d_s1");
        do_sec("d_s2");
        chk("roll_h", 32'(bus.nowH), 0);
        chk("roll_m", 32'(bus.nowM), 0);
        do_sec("d_s3");
        do_sec("d_s4");
        chk("m_01", 32'(bus.nowM), 1);

        do_mode("e_to0");
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (2) @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (20) @(negedge clk);
        push("glitch");
        drain();
        do_up("held", 50);
        chk("held_once", 32'(bus.nowH), 10);

        do_mode("f_to1");
        do_mode("f_to2");
        do_both("both");
        chk("both_st", 32'(bus.master_status), 3);
        for (int i = 0; i < 5; i++) do_mode("f_torun");
        do_up("run_up", 10);
        do_mode("f_to0");
        do_up("f_h20", 10);

        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (3) @(negedge clk);
        do_reset("rst_mid");
        repeat (20) @(negedge clk);
        push("post_rst");
        drain();

        alarm_setup();
`ifdef TIME_SET_ALARM_EN
        chk("alarm_set", 32'(bus.alarm), 1);
`endif
        do_sec("a_s3");
        do_sec("a_s4");
        do_sec("a_s5");
        chk("alarm_off", 32'(bus.alarm), 0);

        do_reset("rst_a");
        alarm_setup();
        do_up("a_kill", 10);
        chk("kill_st", 32'(bus.master_status), 8);
        chk("kill_al", 32'(bus.alarm), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
